// File: rtl/badvaddr_bank_if.sv
// badvaddr_bank_if
//   Bundle of the fault-reporting and handler-side signals of badvaddr_bank.
//   master : pipeline/handler side (drives strobes, addresses, ack and pop)
//   slave  : badvaddr_bank itself (drives architectural value and history view)
//   Signals:
//     addr_err   [NSRC]      per-source address-error strobe
//     badvaddr_p [NSRC*AW]   packed fault addresses, source i at [i*AW +: AW]
//     exc_ack                handler return, releases lock and clears overflow
//     r_h                    handler pop of the history head
//     read_data  [AW]        architectural BadVAddr
//     cap_src    [SW]        source index of read_data
//     locked                 BadVAddr held until exc_ack
//     hist_data  [AW]        history head address (0 when empty)
//     hist_src   [SW]        history head source (0 when empty)
//     hist_valid             history non-empty
//     hist_count [CW]        entries held, 0..DEPTH
//     overflow               sticky: a fault was dropped on a full history
interface badvaddr_bank_if #(
    parameter int AW    = 32,
    parameter int NSRC  = 3,
    parameter int DEPTH = 4
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [NSRC-1:0]    addr_err;
    logic [NSRC*AW-1:0] badvaddr_p;
    logic               exc_ack;
    logic               r_h;
    logic [AW-1:0]      read_data;
    logic [SW-1:0]      cap_src;
    logic               locked;
    logic [AW-1:0]      hist_data;
    logic [SW-1:0]      hist_src;
    logic               hist_valid;
    logic [CW-1:0]      hist_count;
    logic               overflow;

    modport master (
        output addr_err, badvaddr_p, exc_ack, r_h,
        input  read_data, cap_src, locked, hist_data, hist_src,
               hist_valid, hist_count, overflow
    );

    modport slave (
        input  addr_err, badvaddr_p, exc_ack, r_h,
        output read_data, cap_src, locked, hist_data, hist_src,
               hist_valid, hist_count, overflow
    );
endinterface

// File: rtl/badvaddr_bank.sv
// badvaddr_bank
//   Multi-source BadVAddr register. The lowest-indexed faulting source wins,
//   its address is latched into read_data and held (locked) until the handler
//   acknowledges with exc_ack. Every winning fault is also pushed into a
//   DEPTH-entry history FIFO which the handler drains with r_h.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   badvaddr_bank_if.slave (strobes, addresses, ack/pop, outputs)
module badvaddr_bank #(
    parameter int AW    = 32,
    parameter int NSRC  = 3,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    badvaddr_bank_if.slave    bus
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Lowest set bit of the strobe vector.
    function automatic logic [SW-1:0] first_set(input logic [NSRC-1:0] vec);
        logic [SW-1:0] idx;
        idx = {SW{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t          state_r;
    logic [AW-1:0]   read_data_r;
    logic [SW-1:0]   cap_src_r;
    logic            locked_r;
    logic            overflow_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   mem_addr_r [DEPTH];
    logic [SW-1:0]   mem_src_r  [DEPTH];

    logic            any_err_s;
    logic [SW-1:0]   win_src_s;
    logic [AW-1:0]   win_addr_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_ok_s;
    logic            drop_s;

    // Winner selection and FIFO handshake decode.
    always_comb begin
        any_err_s  = |bus.addr_err;
        win_src_s  = first_set(bus.addr_err);
        win_addr_s = bus.badvaddr_p[int'(win_src_s) * AW +: AW];
        full_s     = (count_r == CW'(DEPTH));
        empty_s    = (count_r == {CW{1'b0}});
        // A pop on an empty FIFO is ignored, even if a push lands the same cycle.
        pop_s      = bus.r_h & ~empty_s;
        // A full FIFO still accepts a push when a pop frees the head slot.
        push_ok_s  = any_err_s & (~full_s | pop_s);
        drop_s     = any_err_s & full_s & ~pop_s;
    end

    // History FIFO storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_r[i] <= {AW{1'b0}};
                mem_src_r[i]  <= {SW{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_addr_r[wr_ptr_r] <= win_addr_s;
                mem_src_r[wr_ptr_r]  <= win_src_s;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a same-cycle drop wins over the clearing ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.exc_ack) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Lock FSM with the architectural BadVAddr value as registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_UNLOCKED;
            locked_r    <= 1'b0;
            read_data_r <= {AW{1'b0}};
            cap_src_r   <= {SW{1'b0}};
        end else begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (any_err_s) begin
                        state_r     <= ST_LOCKED;
                        locked_r    <= 1'b1;
                        read_data_r <= win_addr_s;
                        cap_src_r   <= win_src_s;
                    end else begin
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (any_err_s && bus.exc_ack) begin
                        // Release and immediate re-capture in one cycle.
                        state_r     <= ST_LOCKED;
                        locked_r    <= 1'b1;
                        read_data_r <= win_addr_s;
                        cap_src_r   <= win_src_s;
                    end else if (bus.exc_ack) begin
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                    end else begin
                        state_r  <= ST_LOCKED;
                        locked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_UNLOCKED;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_data  = read_data_r;
    assign bus.cap_src    = cap_src_r;
    assign bus.locked     = locked_r;
    assign bus.overflow   = overflow_r;
    assign bus.hist_count = count_r;
    assign bus.hist_valid = ~empty_s;
    // Head is read straight from storage and masked to zero when empty.
    assign bus.hist_data  = empty_s ? {AW{1'b0}} : mem_addr_r[rd_ptr_r];
    assign bus.hist_src   = empty_s ? {SW{1'b0}} : mem_src_r[rd_ptr_r];

endmodule

// File: tb/tb_badvaddr_bank.sv
module tb_badvaddr_bank;
    localparam int AW    = 32;
    localparam int NSRC  = 3;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [AW-1:0] addr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    badvaddr_bank_if #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

    badvaddr_bank #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t          q[$];
    logic [AW-1:0] m_read   = '0;
    logic [SW-1:0] m_src    = '0;
    logic          m_locked = 1'b0;
    logic          m_ovf    = 1'b0;

    // Behavioural model: evaluates the rules at each edge / reset event.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_read   = '0;
                m_src    = '0;
                m_locked = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                logic    any;
                logic    do_pop;
                logic    drop;
                int      w;
                ent_t    e;
                any = 1'b0;
                w   = 0;
                for (int i = NSRC - 1; i >= 0; i--) begin
                    if (bus.addr_err[i]) begin
                        any = 1'b1;
                        w   = i;
                    end
                end
                e.src  = w[SW-1:0];
                e.addr = bus.badvaddr_p[w*AW +: AW];
                do_pop = bus.r_h && (q.size() > 0);
                drop   = any && (q.size() == DEPTH) && !do_pop;
                if (bus.exc_ack) m_ovf = 1'b0;
                if (drop) m_ovf = 1'b1;
                if (do_pop) void'(q.pop_front());
                if (any && !drop) q.push_back(e);
                if (any && (!m_locked || bus.exc_ack)) begin
                    m_read   = e.addr;
                    m_src    = e.src;
                    m_locked = 1'b1;
                end else if (bus.exc_ack) begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            cmp("read_data",  bus.read_data, m_read);
            cmp("cap_src",    32'(bus.cap_src), 32'(m_src));
            cmp("locked",     32'(bus.locked), 32'(m_locked));
            cmp("overflow",   32'(bus.overflow), 32'(m_ovf));
            cmp("hist_count", 32'(bus.hist_count), q.size());
            cmp("hist_valid", 32'(bus.hist_valid), 32'(q.size() != 0));
            cmp("hist_data",  bus.hist_data, (q.size() != 0) ? q[0].addr : 32'h0);
            cmp("hist_src",   32'(bus.hist_src), (q.size() != 0) ? 32'(q[0].src) : 32'h0);
        end
    end

    task automatic cyc(input logic [2:0] err, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic ack, input logic rh);
        bus.addr_err   = err;
        bus.badvaddr_p = {a2, a1, a0};
        bus.exc_ack    = ack;
        bus.r_h        = rh;
        @(posedge clk);
        #2;
        bus.addr_err   = 3'b000;
        bus.badvaddr_p = '0;
        bus.exc_ack    = 1'b0;
        bus.r_h        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_read_data"},  bus.read_data, 32'h0);
        cmp({tag, "_cap_src"},    32'(bus.cap_src), 32'h0);
        cmp({tag, "_locked"},     32'(bus.locked), 32'h0);
        cmp({tag, "_hist_data"},  bus.hist_data, 32'h0);
        cmp({tag, "_hist_src"},   32'(bus.hist_src), 32'h0);
        cmp({tag, "_hist_valid"}, 32'(bus.hist_valid), 32'h0);
        cmp({tag, "_hist_count"}, 32'(bus.hist_count), 32'h0);
        cmp({tag, "_overflow"},   32'(bus.overflow), 32'h0);
    endtask

    initial begin
        bus.addr_err   = 3'b000;
        bus.badvaddr_p = '0;
        bus.exc_ack    = 1'b0;
        bus.r_h        = 1'b0;
        rst            = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b1;

        // Single capture
        cyc(3'b010, 32'h0, 32'h0000_000F, 32'h0, 1'b0, 1'b0);
        cmp("cap1_read", bus.read_data, 32'h0000_000F);
        cmp("cap1_src", 32'(bus.cap_src), 32'd1);
        cmp("cap1_locked", 32'(bus.locked), 32'd1);
        cmp("cap1_count", 32'(bus.hist_count), 32'd1);
        cmp("cap1_hdata", bus.hist_data, 32'h0000_000F);
        cmp("cap1_hsrc", 32'(bus.hist_src), 32'd1);
        cmp("model_cap1", m_read, 32'h0000_000F);
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        cmp("release_locked", 32'(bus.locked), 32'd0);

        // Priority and lock
        cyc(3'b110, 32'h0, 32'h100, 32'h200, 1'b0, 1'b0);
        cmp("prio_read", bus.read_data, 32'h100);
        cmp("prio_src", 32'(bus.cap_src), 32'd1);
        cyc(3'b001, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
        cmp("lock_hold", bus.read_data, 32'h100);
        cmp("lock_count", 32'(bus.hist_count), 32'd2);
        cmp("lock_head0", bus.hist_data, 32'h100);
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cmp("lock_head1", bus.hist_data, 32'h300);
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cmp("lock_empty", 32'(bus.hist_valid), 32'd0);

        // Ack collision
        cyc(3'b100, 32'h0, 32'h0, 32'h400, 1'b1, 1'b0);
        cmp("coll_read", bus.read_data, 32'h400);
        cmp("coll_src", 32'(bus.cap_src), 32'd2);
        cmp("coll_locked", 32'(bus.locked), 32'd1);
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

        // Overflow
        for (int i = 1; i <= 5; i++) cyc(3'b001, 32'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0);
        cmp("ovf_count", 32'(bus.hist_count), 32'd4);
        cmp("ovf_flag", 32'(bus.overflow), 32'd1);
        cmp("model_ovf", 32'(m_ovf), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cmp("ovf_drain", bus.hist_data, 32'(i * 16));
            cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        cmp("ovf_clear", 32'(bus.overflow), 32'd0);
        cmp("ovf_unlock", 32'(bus.locked), 32'd0);

        // Full push + pop
        for (int i = 1; i <= 4; i++) cyc(3'b001, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(3'b001, 32'hAA, 32'h0, 32'h0, 1'b0, 1'b1);
        cmp("fpp_count", 32'(bus.hist_count), 32'd4);
        cmp("fpp_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            cmp("fpp_drain", bus.hist_data, (i == 5) ? 32'hAA : 32'(i));
            cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        end

        // Reset mid-operation
        for (int i = 5; i <= 7; i++) cyc(3'b001, 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
        cmp("mid_count", 32'(bus.hist_count), 32'd3);
        cmp("mid_locked", 32'(bus.locked), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        cmp("post_rst_count", 32'(bus.hist_count), 32'd0);
        cmp("post_rst_valid", 32'(bus.hist_valid), 32'd0);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            logic [2:0] err;
            err = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b0;
                @(posedge clk);
                #2;
                rst = 1'b1;
            end
            cyc(err, $urandom, $urandom, $urandom,
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/badvaddr_bank.md
# badvaddr_bank

Parametrised successor to the single-source BadVAddr register in CP0. Accepts address-error strobes from NSRC pipeline sources (instruction fetch, load, store, …). Selects one by fixed priority and latches its address into the architectural BadVAddr value. Locks that value until the exception handler acknowledges it, and records every reported fault in a DEPTH-entry history FIFO that the handler drains one entry at a time.

## Interface
Parameters:
- AW, 32, address width
- NSRC, 3, number of address-error sources (≥1)
- DEPTH, 4, history FIFO entries (power of two, ≥2)
- SW, $clog2(NSRC) (min 1), source-id width
- CW, $clog2(DEPTH+1), history count width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- addr_err  in  NSRC  per-source address-error strobe, one bit per source
- badvaddr_p  in  NSRC*AW  packed fault addresses; source i at [i*AW +: AW]
- exc_ack  in  1  handler return (eret); releases lock, clears overflow
- r_h  in  1  handler pop of history head
- read_data  out  AW  architectural BadVAddr
- cap_src  out  SW  source index of the value in read_data
- locked  out  1  BadVAddr held, awaiting exc_ack
- hist_data  out  AW  history head address
- hist_src  out  SW  history head source index
- hist_valid  out  1  history non-empty
- hist_count  out  CW  entries held, 0..DEPTH
- overflow  out  1  sticky: a fault was dropped because the FIFO was full

## Operation
- Winner selection: the lowest set index of addr_err wins. Its address is badvaddr_p[win*AW +: AW]. Only the winner is recorded. Losing sources in the same cycle are discarded.
- Two-state FSM, UNLOCKED and LOCKED. `locked` is 1 in LOCKED.
  - UNLOCKED, any addr_err: load read_data and cap_src from the winner, push the winner, go to LOCKED.
  - UNLOCKED, no addr_err: hold; exc_ack is ignored except for clearing overflow.
  - LOCKED, addr_err without exc_ack: read_data and cap_src hold; the winner is pushed to history only.
  - LOCKED, exc_ack without addr_err: go to UNLOCKED; read_data holds its last value.
  - LOCKED, exc_ack with addr_err: treat as release followed by a new capture. read_data and cap_src take the new winner, the winner is pushed, and the state stays LOCKED.
- History FIFO: circular buffer with wrapping read and write pointers modulo DEPTH. Each entry holds {src, addr}.
  - A push while full with no pop is dropped, and overflow is set.
  - A push while full together with r_h: both happen, count stays DEPTH, no overflow.
  - r_h while empty is ignored; count never underflows.
  - A push while empty together with r_h: the push happens and the pop is ignored, because the head was not valid when r_h was sampled.
- hist_data and hist_src show the head entry combinationally from storage. Both are forced to 0 when hist_valid=0.
- overflow clears on any exc_ack. If exc_ack and a dropping push happen in the same cycle, overflow ends at 1.
- rst low mid-operation: all state clears immediately and asynchronously. FIFO contents are invalidated; pointers and count go to 0.

## Timing
- Reset values: read_data=0, cap_src=0, locked=0, hist_data=0, hist_src=0, hist_valid=0, hist_count=0, overflow=0.
- Capture latency is 1 cycle. If addr_err is sampled high at edge n, read_data, cap_src, locked and the history entry are visible after edge n.
- A pop takes effect at the edge where r_h is sampled. The next head is visible after that edge.
- exc_ack sampled at edge n: locked=0 after edge n, unless the same-cycle capture rule applies.
- No combinational path from any input to any output except storage-to-hist_data/hist_src head selection.
- Pointers, count and the FSM state are registered.

## Test plan
- Reset and single capture: hold rst low for 2 cycles, check all outputs are 0. Release rst, pulse addr_err=3'b010 with src1 address 0x0000_000F. After that edge: read_data=0x0000000F, cap_src=1, locked=1, hist_count=1, hist_data=0x0000000F, hist_src=1.
- Priority and lock: addr_err=3'b110 with src1=0x100 and src2=0x200 gives read_data=0x100, cap_src=1. Then addr_err=3'b001 with src0=0x300 while locked: read_data stays 0x100, hist_count=2. Pop twice with r_h: hist_data goes 0x100, then 0x300, then hist_valid=0.
- Overflow (DEPTH=4): push 5 faults 0x10..0x50 with no pops. Check hist_count=4, overflow=1, and that popping returns 0x10, 0x20, 0x30, 0x40. Then exc_ack gives overflow=0 and locked=0.
- Full push+pop: fill to 4 entries, then assert addr_err=3'b001 (0xAA) and r_h together. Check hist_count=4, overflow=0, and that the tail entry is 0xAA after draining.
- Ack collision: while LOCKED with read_data=0x100, assert exc_ack and addr_err=3'b100 (0x400) together. Check read_data=0x400, cap_src=2, locked=1.
- Reset mid-operation: with 3 entries queued and locked=1, drop rst asynchronously between edges. All outputs go to 0 before the next clk edge. r_h after release of rst has no effect.
